// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request -> up to two word-aligned bus beats -> one-cycle extended response.
// Latency: 2 cycles aligned, 3 cycles split, 1 cycle fault, plus one per mem_ready stall; req_ready low until RESP completes.
module mem_access_unit #(
    parameter int XLEN           = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault
);
    localparam int W  = XLEN / 8;
    localparam int OB = $clog2(W);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_size;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rd0;
    logic              r_cross;

    logic              w_sel_req;
    logic [2:0]        w_size;
    logic [XLEN-1:0]   w_addr;
    logic [XLEN-1:0]   w_wdata;
    logic [OB-1:0]     w_off;
    logic [4:0]        w_nbytes;
    logic [OB-1:0]     w_nm1;
    logic [2*W-1:0]    w_nmask;
    logic              w_illegal;
    logic              w_mis;
    logic [4:0]        w_end;
    logic              w_cross;
    logic [2*W-1:0]    w_strb2;
    logic [2*XLEN-1:0] w_data2;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_load_resp;
    logic              w_last;

    // Lane geometry comes from the live request while idle, from the latched copy afterwards.
    assign w_sel_req = (r_state == IDLE);
    assign w_size    = w_sel_req ? req_size  : r_size;
    assign w_addr    = w_sel_req ? req_addr  : r_addr;
    assign w_wdata   = w_sel_req ? req_wdata : r_wdata;
    assign w_off     = w_addr[OB-1:0];

    always_comb begin
        w_nbytes = 5'd1;
        w_nm1    = '0;
        w_nmask  = (2*W)'(8'h01);
        case (w_size[1:0])
            2'b01: begin w_nbytes = 5'd2; w_nm1 = OB'(1); w_nmask = (2*W)'(8'h03); end
            2'b10: begin w_nbytes = 5'd4; w_nm1 = OB'(3); w_nmask = (2*W)'(8'h0F); end
            2'b11: begin w_nbytes = 5'd8; w_nm1 = OB'(7); w_nmask = (2*W)'(8'hFF); end
            default: ;
        endcase
    end

    assign w_illegal = (w_size == 3'b111) ||
                       ((XLEN == 32) && ((w_size == 3'b011) || (w_size == 3'b110)));
    assign w_mis     = (w_off & w_nm1) != '0;
    assign w_end     = 5'(w_off) + w_nbytes;
    assign w_cross   = w_end > 5'(W);
    // Low half of the double-width lane image is beat 0, high half is beat 1.
    assign w_strb2   = w_nmask << w_off;
    assign w_data2   = {{XLEN{1'b0}}, w_wdata} << {w_off, 3'b000};
    assign w_base    = {w_addr[XLEN-1:OB], {OB{1'b0}}};

    assign w_hi      = (r_state == BEAT1) ? mem_rdata : '0;
    assign w_lo      = (r_state == BEAT1) ? r_rd0     : mem_rdata;
    assign w_raw     = XLEN'({w_hi, w_lo} >> {r_addr[OB-1:0], 3'b000});

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] sz);
        int sh;
        case (sz[1:0])
            2'b00:   sh = XLEN - 8;
            2'b01:   sh = XLEN - 16;
            2'b10:   sh = XLEN - 32;
            default: sh = 0;
        endcase
        if (sz[2]) extend = (raw << sh) >> sh;
        else       extend = XLEN'($signed(raw << sh) >>> sh);
    endfunction

    assign w_load_resp = r_we ? '0 : extend(w_raw, r_size);
    assign w_last      = (r_state == BEAT1) || !r_cross;
    assign req_ready   = (r_state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd0      <= '0;
            r_cross    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_fault <= 1'b0;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cross <= w_cross;
                        if (w_illegal || (w_mis && !MISALIGN_SPLIT)) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            r_state   <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= w_base;
                            mem_wstrb <= req_we ? w_strb2[W-1:0] : '0;
                            mem_wdata <= req_we ? w_data2[XLEN-1:0] : '0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (mem_ready) begin
                        r_rd0 <= mem_rdata;
                        if (!w_last) begin
                            r_state   <= BEAT1;
                            mem_addr  <= mem_addr + XLEN'(W);
                            mem_wstrb <= r_we ? w_strb2[2*W-1:W] : '0;
                            mem_wdata <= r_we ? w_data2[2*XLEN-1:XLEN] : '0;
                        end else begin
                            r_state    <= RESP;
                            mem_valid  <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= '0;
                            mem_wstrb  <= '0;
                            mem_wdata  <= '0;
                            resp_valid <= 1'b1;
                            resp_rdata <= w_load_resp;
                            resp_fault <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_fault <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (32-bit split, 32-bit fault, 64-bit split) behind one request driver.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_rdata = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    logic a_rv, a_rr, a_mv, a_mw, a_resv, a_resf;
    logic [31:0] a_ma, a_md, a_resd;
    logic [3:0]  a_ms;
    logic b_rv, b_rr, b_mv, b_mw, b_resv, b_resf;
    logic [31:0] b_ma, b_md, b_resd;
    logic [3:0]  b_ms;
    logic c_rv, c_rr, c_mv, c_mw, c_resv, c_resf;
    logic [63:0] c_ma, c_md, c_resd;
    logic [7:0]  c_ms;

    assign a_rv = req_valid && (sel == 0);
    assign b_rv = req_valid && (sel == 1);
    assign c_rv = req_valid && (sel == 2);

    mem_access_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_rv), .req_ready(a_rr), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .mem_valid(a_mv), .mem_ready(mem_ready), .mem_we(a_mw), .mem_addr(a_ma),
        .mem_wstrb(a_ms), .mem_wdata(a_md), .mem_rdata(mem_rdata[31:0]),
        .resp_valid(a_resv), .resp_rdata(a_resd), .resp_fault(a_resf));

    mem_access_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_rv), .req_ready(b_rr), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .mem_valid(b_mv), .mem_ready(mem_ready), .mem_we(b_mw), .mem_addr(b_ma),
        .mem_wstrb(b_ms), .mem_wdata(b_md), .mem_rdata(mem_rdata[31:0]),
        .resp_valid(b_resv), .resp_rdata(b_resd), .resp_fault(b_resf));

    mem_access_unit #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) u_c (
        .clk(clk), .rst(rst), .req_valid(c_rv), .req_ready(c_rr), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(c_mv), .mem_ready(mem_ready), .mem_we(c_mw), .mem_addr(c_ma),
        .mem_wstrb(c_ms), .mem_wdata(c_md), .mem_rdata(mem_rdata),
        .resp_valid(c_resv), .resp_rdata(c_resd), .resp_fault(c_resf));

    logic        o_req_ready, o_mem_valid, o_mem_we, o_resp_valid, o_resp_fault;
    logic [63:0] o_mem_addr, o_mem_wdata, o_resp_rdata;
    logic [7:0]  o_mem_wstrb;

    assign o_req_ready  = (sel == 0) ? a_rr   : (sel == 1) ? b_rr   : c_rr;
    assign o_mem_valid  = (sel == 0) ? a_mv   : (sel == 1) ? b_mv   : c_mv;
    assign o_mem_we     = (sel == 0) ? a_mw   : (sel == 1) ? b_mw   : c_mw;
    assign o_resp_valid = (sel == 0) ? a_resv : (sel == 1) ? b_resv : c_resv;
    assign o_resp_fault = (sel == 0) ? a_resf : (sel == 1) ? b_resf : c_resf;
    assign o_mem_addr   = (sel == 0) ? {32'b0, a_ma}   : (sel == 1) ? {32'b0, b_ma}   : c_ma;
    assign o_mem_wdata  = (sel == 0) ? {32'b0, a_md}   : (sel == 1) ? {32'b0, b_md}   : c_md;
    assign o_resp_rdata = (sel == 0) ? {32'b0, a_resd} : (sel == 1) ? {32'b0, b_resd} : c_resd;
    assign o_mem_wstrb  = (sel == 0) ? {4'b0, a_ms}    : (sel == 1) ? {4'b0, b_ms}    : c_ms;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sparse byte-addressed memory; untouched bytes read as an address-derived pattern.
    logic [7:0] mem [logic [63:0]];

    function automatic logic [7:0] byte_at(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'(a ^ (a >> 5) ^ 64'h5A);
    endfunction

    int          t_beats, t_lat, t_strb_bits;
    logic [63:0] t_a [2];
    logic [63:0] t_d [2];
    logic [7:0]  t_s [2];
    logic [63:0] t_rdata;
    logic        t_fault, t_stable, t_after_ok;

    task automatic run_req(input int k, input logic we, input logic [2:0] size,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] rd0, input logic [63:0] rd1,
                           input bit use_mem, input int wt);
        int w, waited, rec, cyc, guard;
        logic [63:0] word;
        w = (k == 2) ? 8 : 4;
        sel = k;
        t_beats = 0; t_lat = -1; t_strb_bits = 0; t_rdata = '0; t_fault = 1'b0; t_stable = 1'b1;
        for (int i = 0; i < 2; i++) begin t_a[i] = '0; t_d[i] = '0; t_s[i] = '0; end
        rec = -1; waited = 0;
        @(negedge clk);
        guard = 0;
        while (!o_req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            mem_ready = 1'b0;
            if (o_resp_valid) begin
                t_lat = cyc; t_rdata = o_resp_rdata; t_fault = o_resp_fault;
                break;
            end
            if (o_mem_valid) begin
                if (t_beats < 2) begin
                    if (rec != t_beats) begin
                        rec = t_beats;
                        t_a[t_beats] = o_mem_addr; t_s[t_beats] = o_mem_wstrb; t_d[t_beats] = o_mem_wdata;
                    end else if (o_mem_addr !== t_a[t_beats] || o_mem_wstrb !== t_s[t_beats] ||
                                 o_mem_wdata !== t_d[t_beats]) begin
                        t_stable = 1'b0;
                    end
                end
                if (t_beats == 0 && waited < wt) begin
                    waited++;
                end else begin
                    mem_ready = 1'b1;
                    t_strb_bits += $countones(o_mem_wstrb);
                    if (use_mem) begin
                        word = '0;
                        for (int i = 0; i < w; i++) begin
                            word |= 64'(byte_at(o_mem_addr + 64'(i))) << (8 * i);
                            if (o_mem_we && o_mem_wstrb[i]) mem[o_mem_addr + 64'(i)] = o_mem_wdata[8*i +: 8];
                        end
                        mem_rdata = word;
                    end else begin
                        mem_rdata = (t_beats == 0) ? rd0 : rd1;
                    end
                    t_beats++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        t_after_ok = !o_resp_valid && o_req_ready && !o_mem_valid;
    endtask

    typedef struct {
        int k; logic we; logic [2:0] size; logic [63:0] addr, wd, rd0, rd1; int wt;
        int beats; logic [63:0] a0; logic [7:0] s0; logic [63:0] d0;
        logic [63:0] a1; logic [7:0] s1; logic [63:0] d1;
        logic [63:0] rdata; logic fault; int lat;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic bad;
        vt[0]  = '{0, 0, 3'b000, 'h103, 0, 'h80AABBCC, 0, 0, 1, 'h100, 0, 0, 0, 0, 0, 'hFFFFFF80, 0, 2};
        vt[1]  = '{0, 0, 3'b100, 'h103, 0, 'h80AABBCC, 0, 0, 1, 'h100, 0, 0, 0, 0, 0, 'h80, 0, 2};
        vt[2]  = '{0, 1, 3'b001, 'h102, 'h1234, 0, 0, 0, 1, 'h100, 'b1100, 'h12340000, 0, 0, 0, 0, 0, 2};
        vt[3]  = '{0, 0, 3'b010, 'h203, 0, 'h11223344, 'h55667788, 0, 2, 'h200, 0, 0, 'h204, 0, 0, 'h66778811, 0, 3};
        vt[4]  = '{0, 1, 3'b010, 'h203, 'hAABBCCDD, 0, 0, 0, 2, 'h200, 'b1000, 'hDD000000, 'h204, 'b0111, 'h00AABBCC, 0, 0, 3};
        vt[5]  = '{1, 0, 3'b001, 'h101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[6]  = '{0, 0, 3'b011, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[7]  = '{1, 0, 3'b011, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[8]  = '{0, 0, 3'b010, 'h100, 0, 'hDEADBEEF, 0, 3, 1, 'h100, 0, 0, 0, 0, 0, 'hDEADBEEF, 0, 5};
        vt[9]  = '{2, 0, 3'b110, 'h4, 0, 'h8000000100000000, 0, 0, 1, 'h0, 0, 0, 0, 0, 0, 'h80000001, 0, 2};
        vt[10] = '{2, 0, 3'b010, 'h4, 0, 'h8000000100000000, 0, 0, 1, 'h0, 0, 0, 0, 0, 0, 'hFFFFFFFF80000001, 0, 2};
        vt[11] = '{0, 0, 3'b001, 'h101, 0, 'h11A2B344, 0, 0, 1, 'h100, 0, 0, 0, 0, 0, 'hFFFFA2B3, 0, 2};
        vt[12] = '{2, 0, 3'b011, 'h8, 0, 'h0123456789ABCDEF, 0, 0, 1, 'h8, 0, 0, 0, 0, 0, 'h0123456789ABCDEF, 0, 2};
        vt[13] = '{2, 1, 3'b001, 'h7, 'hBEEF, 0, 0, 0, 2, 'h0, 'h80, 'hEF00000000000000, 'h8, 'h01, 'hBE, 0, 0, 3};
        vt[14] = '{0, 1, 3'b111, 'h100, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[15] = '{2, 0, 3'b010, 'h6, 0, 'h1122334455667788, 'h99AABBCCDDEEFF00, 0, 2, 'h0, 0, 0, 'h8, 0, 0, 'hFFFFFFFFFF001122, 0, 3};
        vt[16] = '{1, 1, 3'b010, 'h102, 'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[17] = '{1, 0, 3'b000, 'h103, 0, 'h80AABBCC, 0, 0, 1, 'h100, 0, 0, 0, 0, 0, 'hFFFFFF80, 0, 2};

        // Reset state of every instance.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            chk("rst_req_ready", 64'(o_req_ready), 0);
            chk("rst_mem_valid", 64'(o_mem_valid), 0);
            chk("rst_mem_addr", o_mem_addr, 0);
            chk("rst_mem_wstrb", 64'(o_mem_wstrb), 0);
            chk("rst_resp_valid", 64'(o_resp_valid), 0);
            chk("rst_resp_rdata", o_resp_rdata, 0);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            chk("idle_req_ready", 64'(o_req_ready), 1);
        end

        for (int i = 0; i < 18; i++) begin
            run_req(vt[i].k, vt[i].we, vt[i].size, vt[i].addr, vt[i].wd, vt[i].rd0, vt[i].rd1, 1'b0, vt[i].wt);
            chk($sformatf("v%0d_beats", i), 64'(t_beats), 64'(vt[i].beats));
            chk($sformatf("v%0d_lat", i), 64'(t_lat), 64'(vt[i].lat));
            chk($sformatf("v%0d_fault", i), 64'(t_fault), 64'(vt[i].fault));
            chk($sformatf("v%0d_rdata", i), t_rdata, vt[i].rdata);
            chk($sformatf("v%0d_after", i), 64'(t_after_ok), 1);
            chk($sformatf("v%0d_stable", i), 64'(t_stable), 1);
            if (vt[i].beats >= 1) begin
                chk($sformatf("v%0d_addr0", i), t_a[0], vt[i].a0);
                chk($sformatf("v%0d_strb0", i), 64'(t_s[0]), 64'(vt[i].s0));
                if (vt[i].we) chk($sformatf("v%0d_wdata0", i), t_d[0], vt[i].d0);
            end
            if (vt[i].beats == 2) begin
                chk($sformatf("v%0d_addr1", i), t_a[1], vt[i].a1);
                chk($sformatf("v%0d_strb1", i), 64'(t_s[1]), 64'(vt[i].s1));
                if (vt[i].we) chk($sformatf("v%0d_wdata1", i), t_d[1], vt[i].d1);
            end
        end

        // Reset asserted while the second beat of a split load is pending.
        sel = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 64'h203;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_beat0_valid", 64'(o_mem_valid), 1);
        mem_ready = 1'b1; mem_rdata = 64'h11223344;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("mid_beat1_addr", o_mem_addr, 64'h204);
        #2 rst = 1'b1;
        #1 chk("mid_rst_async_drop", 64'(o_mem_valid), 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("mid_rst_release_ready", 64'(o_req_ready), 1);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_resp_valid || o_mem_valid) bad = 1'b1;
        end
        chk("mid_rst_no_activity", 64'(bad), 0);

        // Randomized traffic against a byte-level memory model.
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 50; it++) begin
                int w, n, off, wt, ebeats, elat;
                logic we, split, illegal, mis, fault;
                logic [2:0] size;
                logic [63:0] addr, wd, ev, got, emask;
                w = (k == 2) ? 8 : 4;
                split = (k != 1);
                we = 1'($urandom % 2);
                size = 3'($urandom % 8);
                addr = 64'h1000 + 64'($urandom_range(0, 255));
                wd = {$urandom, $urandom};
                if (w == 4) wd[63:32] = '0;
                wt = int'($urandom % 3);
                n = 1 << size[1:0];
                off = int'(addr % 64'(w));
                illegal = (size == 3'b111) || (w == 4 && (size == 3'b011 || size == 3'b110));
                mis = (addr % 64'(n)) != 0;
                fault = illegal || (mis && !split);
                ebeats = fault ? 0 : ((off + n > w) ? 2 : 1);
                elat = fault ? 1 : 1 + ebeats + wt;
                ev = '0;
                for (int i = 0; i < n; i++) ev |= 64'(byte_at(addr + 64'(i))) << (8 * i);
                if (!size[2] && n < 8 && ev[8*n-1]) ev |= ~64'd0 << (8 * n);
                if (w == 4) ev &= 64'hFFFFFFFF;
                if (we || fault) ev = '0;
                run_req(k, we, size, addr, wd, 0, 0, 1'b1, wt);
                chk($sformatf("r%0d_%0d_beats", k, it), 64'(t_beats), 64'(ebeats));
                chk($sformatf("r%0d_%0d_lat", k, it), 64'(t_lat), 64'(elat));
                chk($sformatf("r%0d_%0d_fault", k, it), 64'(t_fault), 64'(fault));
                chk($sformatf("r%0d_%0d_rdata", k, it), t_rdata, ev);
                chk($sformatf("r%0d_%0d_strbbits", k, it), 64'(t_strb_bits), (we && !fault) ? 64'(n) : 0);
                if (ebeats > 0) chk($sformatf("r%0d_%0d_addr0", k, it), t_a[0], addr & ~64'(w - 1));
                if (we && !fault) begin
                    got = '0;
                    for (int i = 0; i < n; i++) got |= 64'(byte_at(addr + 64'(i))) << (8 * i);
                    emask = (n == 8) ? ~64'd0 : ~(~64'd0 << (8 * n));
                    chk($sformatf("r%0d_%0d_stored", k, it), got, wd & emask);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
